fetch_prefetch_unit: RTL and testbench

Instruction fetch front end that sits directly upstream of the single-cycle controller/datapath. It generates sequential fetch addresses, issues them to instruction memory over a request/response handshake, and buffers returned words in a small in-order prefetch queue. It presents one instruction at a time with its PC+4 (`NextInstruct`). Branch and jump targets from the controller redirect it, flushing queued and in-flight instructions.

---
 rtl/fetch_prefetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_prefetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Sequential instruction fetch with an in-order prefetch queue.
// Redirects flush the queue and discard responses still in flight.
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic        IMemRespValid,
    input  logic [31:0] IMemRespData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] Instruction,
    output logic [31:0] NextInstruct,
    output logic        InstValid,
    input  logic        InstReady
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_sh_rd;
    logic [AW-1:0] r_sh_wr;
    logic [31:0]   r_q_instr [DEPTH];
    logic [31:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_sh_pc   [DEPTH];

    logic [CW:0]   w_inflight;
    logic          w_req;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic [31:0]   w_resp_pc;
    logic          w_unused_pc_lsb;

    assign w_unused_pc_lsb = ^RedirectPC[1:0];

    // Queued plus outstanding never exceeds DEPTH, so the queue cannot overflow.
    assign w_inflight = {1'b0, r_count} + {1'b0, r_out};
    assign w_req      = Reset & ~Redirect & (w_inflight < (CW+1)'(DEPTH));
    assign w_accept   = w_req & IMemReady;
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid & InstReady & ~Redirect;
    assign w_push     = IMemRespValid & ~Redirect & (r_drop == '0);
    assign w_resp_pc  = r_sh_pc[r_sh_rd];

    assign IMemReq      = w_req;
    assign IMemAddr     = r_fetch_pc;
    assign InstValid    = w_valid;
    assign Instruction  = w_valid ? r_q_instr[r_rd] : 32'h0;
    assign NextInstruct = w_valid ? (r_q_pc[r_rd] + 32'd4) : 32'h0;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_fetch_pc <= RESET_PC;
            r_out      <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_sh_rd    <= '0;
            r_sh_wr    <= '0;
        end else begin
            r_out <= r_out + CW'(w_accept) - CW'(IMemRespValid);
            if (w_accept) begin
                r_sh_wr <= r_sh_wr + AW'(1);
            end
            if (IMemRespValid) begin
                r_sh_rd <= r_sh_rd + AW'(1);
            end
            if (Redirect) begin
                r_fetch_pc <= {RedirectPC[31:2], 2'b00};
                r_drop     <= r_out - CW'(IMemRespValid);
                r_count    <= '0;
                r_rd       <= '0;
                r_wr       <= '0;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (IMemRespValid && r_drop != '0) begin
                    r_drop <= r_drop - CW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_push) begin
                    r_wr <= r_wr + AW'(1);
                end
                if (w_pop) begin
                    r_rd <= r_rd + AW'(1);
                end
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the counters above.
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_sh_pc[r_sh_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_q_instr[r_wr] <= IMemRespData;
            r_q_pc[r_wr]    <= w_resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: epoch-tagged memory model and
// expected in-order instruction stream; memory word at addr is addr>>2.
module tb_fetch_prefetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic        IMemRespValid;
    logic [31:0] IMemRespData;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] Instruction;
    logic [31:0] NextInstruct;
    logic        InstValid;
    logic        InstReady;

    fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemReady    (IMemReady),
        .IMemRespValid(IMemRespValid),
        .IMemRespData (IMemRespData),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC),
        .Instruction  (Instruction),
        .NextInstruct (NextInstruct),
        .InstValid    (InstValid),
        .InstReady    (InstReady)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } req_t;

    req_t        memq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc;
    int          epoch = 0;
    int          tb_count;
    int          l_fix;
    int          first_valid;
    int          obs_pops;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic reset_model();
        memq.delete();
        tb_count    = 0;
        epoch++;
        exp_pc      = RESET_PC;
        exp_fetch   = RESET_PC;
        cyc         = 0;
        first_valid = -1;
        obs_pops    = 0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", 32'(IMemReq), 32'h0);
        chk("rst_addr", IMemAddr, RESET_PC);
        chk("rst_valid", 32'(InstValid), 32'h0);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_next", NextInstruct, 32'h0);
    endtask

    // Called at a negedge; drives one cycle, checks, advances to next negedge.
    task automatic step(input bit redir, input logic [31:0] rpc,
                        input bit iready, input bit mready);
        logic exp_req;
        bit   accept, pop, resp;
        int   rtag, lat;
        Redirect   = redir;
        RedirectPC = rpc;
        InstReady  = iready;
        IMemReady  = mready;
        resp = (memq.size() > 0) && (memq[0].due <= cyc);
        rtag = resp ? memq[0].ep : -1;
        IMemRespValid = resp;
        IMemRespData  = resp ? (memq[0].addr >> 2) : $urandom;
        #1;
        exp_req = !redir && (tb_count + memq.size() < DEPTH);
        chk("req", 32'(IMemReq), 32'(exp_req));
        if (exp_req) chk("addr", IMemAddr, exp_fetch);
        chk("valid", 32'(InstValid), 32'(tb_count != 0));
        if (tb_count != 0) begin
            chk("instr", Instruction, exp_pc >> 2);
            chk("next", NextInstruct, exp_pc + 32'd4);
        end else begin
            chk("instr_empty", Instruction, 32'h0);
            chk("next_empty", NextInstruct, 32'h0);
        end
        if (InstValid === 1'b1 && first_valid < 0) first_valid = cyc;
        if (InstValid === 1'b1 && iready && !redir) obs_pops++;
        accept = exp_req && mready;
        pop    = (tb_count != 0) && iready && !redir;
        @(posedge Clk);
        if (resp) void'(memq.pop_front());
        if (accept) begin
            lat = (l_fix > 0) ? l_fix : int'($urandom_range(1, 4));
            memq.push_back('{addr: exp_fetch, ep: epoch, due: cyc + lat});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redir) begin
            epoch++;
            tb_count  = 0;
            exp_pc    = {rpc[31:2], 2'b00};
            exp_fetch = {rpc[31:2], 2'b00};
        end else begin
            if (resp && rtag == epoch) tb_count++;
            if (pop) begin
                tb_count--;
                exp_pc = exp_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge Clk);
    endtask

    task automatic async_reset();
        #2;
        Reset         = 1'b0;
        IMemRespValid = 1'b0;
        Redirect      = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        reset_model();
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (InstValid !== 1'b1 && i < 20) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            i++;
        end
        chk(tag, 32'(i < 20), 32'h1);
    endtask

    initial begin
        Reset = 1'b0; IMemReady = 1'b0; IMemRespValid = 1'b0;
        IMemRespData = '0; Redirect = 1'b0; RedirectPC = '0; InstReady = 1'b0;
        l_fix = 1;
        #3;
        chk_reset_outputs();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        reset_model();

        // Free run, L=1
        for (int i = 0; i < 22; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("first_valid_cycle", 32'(first_valid), 32'd2);
        chk("throughput_pops", 32'(obs_pops), 32'd20);

        // Async reset mid-burst, then backpressure with L=3
        async_reset();
        l_fix = 3;
        for (int i = 0; i < 14; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("bp_req_low", 32'(IMemReq), 32'h0);
        chk("bp_full", 32'(InstValid), 32'h1);
        chk("bp_head", Instruction, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp_drained", 32'(InstValid), 32'h0);

        // Redirect with 1 queued, 2 in flight, response and pop same cycle
        async_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_redir_valid", 32'(InstValid), 32'h1);
        step(1'b1, 32'h0000_0103, 1'b1, 1'b1);
        chk("redir_flush", 32'(InstValid), 32'h0);
        wait_valid("redir_wait");
        chk("redir_instr", Instruction, 32'h40);
        chk("redir_next", NextInstruct, 32'h104);

        // PC wrap
        l_fix = 1;
        step(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        wait_valid("wrap_wait");
        chk("wrap_instr", Instruction, 32'h3FFF_FFFF);
        chk("wrap_next", NextInstruct, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Randomized traffic
        l_fix = 0;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 4, $urandom,
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 80);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
